router_pkt_fifo: RTL and testbench

Parametrised packet-aware FIFO for one router output channel, the successor of the fixed 16×8 router FIFO. It stores header-tagged words written by the router FSM, tracks packet boundaries on the read side from the header length field, and reports occupancy, almost-full and packet framing to the synchroniser and output logic. Storage is a true circular buffer: pointers wrap and never need an idle-time reset.

---
 rtl/router_pkt_fifo.sv | 105 ++++++++++
 tb/tb_router_pkt_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/router_pkt_fifo.sv
// Packet-aware circular FIFO for one router output channel.
// Tags each stored word with its header flag and frames packets on the read side.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     read_enb,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     sop,
  output logic                     eop,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REM_W = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [REM_W-1:0]      rem;
  logic [DATA_WIDTH:0]   rd_word;
  logic [CNT_W-1:0]      count_nxt;
  logic                  wr_ok;
  logic                  pop;
  logic                  flush;

  assign flush   = reset || soft_reset;
  assign wr_ok   = write_enb && !full;
  assign pop     = read_enb && !empty;
  assign rd_word = mem[rd_ptr];

  // Remaining words of a packet: payload length from the header plus the parity word.
  function automatic logic [REM_W-1:0] hdr_rem(input logic [DATA_WIDTH-1:0] hdr);
    return {1'b0, hdr[DATA_WIDTH-1:2]} + REM_W'(1);
  endfunction

  always_comb begin
    count_nxt = count;
    case ({wr_ok, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage: no reset, stale entries become unreachable once pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush)
      mem[wr_ptr] <= {lfd_state, data_in};
  end

  // Pointers, occupancy flags and the registered read stage.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rem         <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_drop     <= 1'b0;
      data_valid  <= 1'b0;
      sop         <= 1'b0;
      eop         <= 1'b0;
      data_out    <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == FULL_LEVEL);
      almost_full <= (count_nxt >= AF_LEVEL);
      wr_drop     <= write_enb && full;
      data_valid  <= pop;
      sop         <= pop && rd_word[DATA_WIDTH];
      eop         <= pop && !rd_word[DATA_WIDTH] && (rem == REM_W'(1));
      if (pop) begin
        data_out <= rd_word[DATA_WIDTH-1:0];
        if (rd_word[DATA_WIDTH])
          rem <= hdr_rem(rd_word[DATA_WIDTH-1:0]);
        else if (rem != '0)
          rem <= rem - REM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AF = 2;

  logic          clk = 1'b0;
  logic          reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid, sop, eop, empty, full, almost_full, wr_drop;
  logic [4:0]    count;

  router_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AF_MARGIN(AF)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb),
    .data_out(data_out), .data_valid(data_valid), .sop(sop), .eop(eop),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of {header flag, data} plus a remaining-word counter.
  logic [DW:0]   q[$];
  int            mrem = 0;
  logic [DW-1:0] exp_dout = '0;
  bit            exp_valid, exp_sop, exp_eop, exp_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit sr, input bit we, input bit lfd,
                      input logic [DW-1:0] din, input bit re);
    logic [DW:0] w;
    bit was_full, do_pop;
    reset = r; soft_reset = sr; write_enb = we; lfd_state = lfd;
    data_in = din; read_enb = re;
    @(posedge clk);
    exp_valid = 0; exp_sop = 0; exp_eop = 0; exp_drop = 0;
    if (r || sr) begin
      q.delete();
      mrem = 0;
      exp_dout = '0;
    end else begin
      was_full = (q.size() == D);
      do_pop   = re && (q.size() > 0);
      exp_drop = we && was_full;
      if (do_pop) begin
        w = q.pop_front();
        exp_valid = 1;
        exp_dout = w[DW-1:0];
        if (w[DW]) begin
          exp_sop = 1;
          mrem = int'(w[DW-1:2]) + 1;
        end else if (mrem > 0) begin
          exp_eop = (mrem == 1);
          mrem--;
        end
      end
      if (we && !was_full) q.push_back({lfd, din});
    end
    #1;
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("data_valid", 32'(data_valid), 32'(exp_valid));
    chk("sop", 32'(sop), 32'(exp_sop));
    chk("eop", 32'(eop), 32'(exp_eop));
    chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= D - AF));
  endtask

  task automatic wr(input bit lfd, input logic [DW-1:0] din);
    step(0, 0, 1, lfd, din, 0);
  endtask

  task automatic rd();
    step(0, 0, 0, 0, '0, 1);
  endtask

  int eop_seen;
  int sop_seen;

  initial begin
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    chk("reset_count_abs", 32'(count), 32'd0);
    chk("reset_empty_abs", 32'(empty), 32'd1);

    // Header 0x0C: 3 payload words plus parity.
    wr(1, 8'h0C); wr(0, 8'hA1); wr(0, 8'hA2); wr(0, 8'hA3); wr(0, 8'h5E);
    chk("pkt_count_abs", 32'(count), 32'd5);
    sop_seen = 0; eop_seen = 0;
    for (int i = 0; i < 5; i++) begin
      rd();
      if (sop) sop_seen += (i + 1);
      if (eop) eop_seen += (i + 1);
    end
    chk("pkt_sop_pos", 32'(sop_seen), 32'd1);
    chk("pkt_eop_pos", 32'(eop_seen), 32'd5);

    // Fill, overflow attempts, drain.
    for (int i = 0; i < D; i++) wr(0, 8'(8'h30 + i));
    wr(0, 8'hEE); wr(0, 8'hEF);
    chk("fill_full_abs", 32'(full), 32'd1);
    for (int i = 0; i < D; i++) rd();
    chk("drain_empty_abs", 32'(empty), 32'd1);

    // Simultaneous write and pop across pointer wraps.
    for (int i = 0; i < 3; i++) wr(0, 8'(i));
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 8'(8'h80 + i), 1);
    for (int i = 0; i < 3; i++) rd();

    // Pop on empty, then write+read on empty.
    rd();
    step(0, 0, 1, 0, 8'h77, 1);
    rd();

    // Mid-packet soft reset.
    wr(1, 8'h10); for (int i = 0; i < 5; i++) wr(0, 8'(8'h40 + i));
    rd(); rd();
    step(0, 1, 1, 0, 8'hDD, 1);
    chk("soft_dout_abs", 32'(data_out), 32'd0);
    wr(1, 8'h04); wr(0, 8'h91); wr(0, 8'h92);
    rd(); rd(); rd();

    // Length-0 packet followed by a length-2 packet.
    wr(1, 8'h01); wr(0, 8'hC0);
    wr(1, 8'h08); wr(0, 8'hC1); wr(0, 8'hC2); wr(0, 8'hC3);
    sop_seen = 0; eop_seen = 0;
    for (int i = 0; i < 6; i++) begin
      rd();
      if (sop) sop_seen = sop_seen * 10 + (i + 1);
      if (eop) eop_seen = eop_seen * 10 + (i + 1);
    end
    chk("len0_sop_pos", 32'(sop_seen), 32'd13);
    chk("len0_eop_pos", 32'(eop_seen), 32'd26);

    // Random traffic with phases biased toward filling or draining.
    for (int blk = 0; blk < 20; blk++) begin
      int wp, rp;
      wp = $urandom_range(20, 90);
      rp = $urandom_range(20, 90);
      for (int i = 0; i < 150; i++) begin
        bit r, sr;
        r  = ($urandom_range(0, 999) == 0);
        sr = ($urandom_range(0, 199) == 0);
        step(r, sr, $urandom_range(0, 99) < wp, $urandom_range(0, 3) == 0,
             8'($urandom), $urandom_range(0, 99) < rp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
